// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises rx, validates the start bit at mid-bit and
// emits each good byte as a one-cycle dataValid strobe for the ring buffer.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       dataValid,
  output logic [7:0] dataOut,
  output logic       framingError,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rxState_t;

  rxState_t         state, stateNext;
  logic [CNT_W-1:0] count, countNext;
  logic [2:0]       bitIndex, bitIndexNext;
  logic [7:0]       shiftReg, shiftNext;
  logic [7:0]       dataOutNext;
  logic             dataValidNext, framingErrorNext;
  logic             rxMeta_p0, syncRx_p1;

  always_comb begin
    stateNext        = state;
    countNext        = count;
    bitIndexNext     = bitIndex;
    shiftNext        = shiftReg;
    dataOutNext      = dataOut;
    dataValidNext    = 1'b0;
    framingErrorNext = 1'b0;
    unique case (state)
      IDLE: begin
        countNext = '0;
        if (!syncRx_p1) stateNext = START;
      end
      START: begin
        // Re-check the line at mid start bit so short glitches fall back to IDLE
        if (count == HALF_BIT) begin
          countNext    = '0;
          bitIndexNext = 3'd0;
          stateNext    = syncRx_p1 ? IDLE : DATA;
        end else begin
          countNext = count + CNT_ONE;
        end
      end
      DATA: begin
        if (count == LAST_CLK) begin
          shiftNext[bitIndex] = syncRx_p1;
          countNext           = '0;
          bitIndexNext        = bitIndex + 3'd1;
          if (bitIndex == 3'd7) stateNext = STOP;
        end else begin
          countNext = count + CNT_ONE;
        end
      end
      STOP: begin
        if (count == LAST_CLK) begin
          countNext = '0;
          if (syncRx_p1) begin
            dataOutNext   = shiftReg;
            dataValidNext = 1'b1;
            stateNext     = IDLE;
          end else begin
            framingErrorNext = 1'b1;
            stateNext        = BREAK;
          end
        end else begin
          countNext = count + CNT_ONE;
        end
      end
      BREAK: begin
        // A held-low line must return high before another start is accepted
        countNext = '0;
        if (syncRx_p1) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta_p0    <= 1'b1;
      syncRx_p1    <= 1'b1;
      state        <= IDLE;
      count        <= '0;
      bitIndex     <= 3'd0;
      shiftReg     <= 8'h00;
      dataOut      <= 8'h00;
      dataValid    <= 1'b0;
      framingError <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchroniser on the asynchronous rx line
      rxMeta_p0    <= rx;
      syncRx_p1    <= rxMeta_p0;
      state        <= stateNext;
      count        <= countNext;
      bitIndex     <= bitIndexNext;
      shiftReg     <= shiftNext;
      dataOut      <= dataOutNext;
      dataValid    <= dataValidNext;
      framingError <= framingErrorNext;
      busy         <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for glitch, break, back-to-back and mid-frame reset.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       dataValid;
  logic [7:0] dataOut;
  logic       framingError;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .dataValid(dataValid),
    .dataOut(dataOut),
    .framingError(framingError),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log captured away from the active edge
  int         vldCyc[$];
  logic [7:0] vldData[$];
  int         ferrCyc[$];
  int         overlapCnt = 0;
  int         repeatCnt = 0;
  logic       prevStrobe = 1'b0;

  always @(negedge clk) begin
    if (dataValid === 1'b1) begin
      vldCyc.push_back(cyc);
      vldData.push_back(dataOut);
    end
    if (framingError === 1'b1) ferrCyc.push_back(cyc);
    if (dataValid === 1'b1 && framingError === 1'b1) overlapCnt <= overlapCnt + 1;
    if ((dataValid === 1'b1 || framingError === 1'b1) && prevStrobe) repeatCnt <= repeatCnt + 1;
    prevStrobe <= (dataValid === 1'b1 || framingError === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drives one frame from a negedge; rx is left at the stop-bit level
  task automatic sendByte(input logic [7:0] b, input logic stopBit, output int startCyc);
    rx = 1'b0;
    startCyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         holdBits;
    int         expVld;
    int         expFerr;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nV, nF, sc, s1, s2, s3, waitCnt;
    logic [7:0] frameByte;

    vecs[0] = '{8'hA5, 1'b1, 0, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
    vecs[3] = '{8'h5A, 1'b1, 0, 1, 0, 8'h5A};
    vecs[4] = '{8'hC3, 1'b0, 3, 0, 1, 8'h5A};
    vecs[5] = '{8'h96, 1'b1, 0, 1, 0, 8'h96};

    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset dataValid", dataValid, 0);
    check("reset busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post-reset dataOut", dataOut, 8'h00);
    check("post-reset dataValid", dataValid, 0);
    check("post-reset framingError", framingError, 0);
    check("post-reset busy", busy, 0);
    repeat (10) @(negedge clk);

    // Single-frame table
    for (int i = 0; i < 6; i++) begin
      nV = vldCyc.size();
      nF = ferrCyc.size();
      sendByte(vecs[i].data, vecs[i].stopBit, sc);
      if (!vecs[i].stopBit) begin
        repeat (vecs[i].holdBits * CPB) @(negedge clk);
        rx = 1'b1;
      end
      repeat (40) @(negedge clk);
      check($sformatf("vec%0d dataValid count", i), vldCyc.size() - nV, vecs[i].expVld);
      check($sformatf("vec%0d framingError count", i), ferrCyc.size() - nF, vecs[i].expFerr);
      check($sformatf("vec%0d dataOut", i), dataOut, vecs[i].expOut);
      check($sformatf("vec%0d busy idle", i), busy, 0);
      if (vecs[i].expVld == 1 && vldCyc.size() > nV)
        checkRange($sformatf("vec%0d latency", i), vldCyc[nV] - sc, 151, 155);
    end

    // Back-to-back frames, one stop bit each
    nV = vldCyc.size();
    nF = ferrCyc.size();
    sendByte(8'h01, 1'b1, s1);
    sendByte(8'hFF, 1'b1, s2);
    repeat (20) @(negedge clk);
    check("b2b count", vldCyc.size() - nV, 2);
    if (vldCyc.size() - nV >= 2) begin
      check("b2b first byte", vldData[nV], 8'h01);
      check("b2b second byte", vldData[nV+1], 8'hFF);
      checkRange("b2b spacing", vldCyc[nV+1] - vldCyc[nV], 159, 161);
    end
    check("b2b framingError", ferrCyc.size() - nF, 0);

    // Three-byte burst delivered in order
    nV = vldCyc.size();
    sendByte(8'h11, 1'b1, s1);
    sendByte(8'h22, 1'b1, s2);
    sendByte(8'h33, 1'b1, s3);
    repeat (20) @(negedge clk);
    check("burst count", vldCyc.size() - nV, 3);
    if (vldCyc.size() - nV >= 3) begin
      check("burst byte0", vldData[nV], 8'h11);
      check("burst byte1", vldData[nV+1], 8'h22);
      check("burst byte2", vldData[nV+2], 8'h33);
    end

    // Short low glitch
    nV = vldCyc.size();
    nF = ferrCyc.size();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    check("glitch busy raised", busy, 1);
    waitCnt = 0;
    while (busy !== 1'b0 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkRange("glitch busy release", waitCnt, 1, 10);
    repeat (20) @(negedge clk);
    check("glitch dataValid", vldCyc.size() - nV, 0);
    check("glitch framingError", ferrCyc.size() - nF, 0);

    // Break: stop bit low, line held low for 20 bit times
    sendByte(8'h81, 1'b1, sc);
    repeat (20) @(negedge clk);
    check("pre-break dataOut", dataOut, 8'h81);
    nV = vldCyc.size();
    nF = ferrCyc.size();
    sendByte(8'h3C, 1'b0, sc);
    repeat (20 * CPB) @(negedge clk);
    check("break busy held", busy, 1);
    check("break framingError count", ferrCyc.size() - nF, 1);
    rx = 1'b1;
    waitCnt = 0;
    while (busy !== 1'b0 && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    check("break busy released", busy, 0);
    check("break dataValid", vldCyc.size() - nV, 0);
    check("break dataOut kept", dataOut, 8'h81);
    repeat (16) @(negedge clk);
    nV = vldCyc.size();
    sendByte(8'h55, 1'b1, sc);
    repeat (20) @(negedge clk);
    check("after-break count", vldCyc.size() - nV, 1);
    check("after-break dataOut", dataOut, 8'h55);

    // Reset during data bit 4 of 0x96
    nV = vldCyc.size();
    nF = ferrCyc.size();
    frameByte = 8'h96;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = frameByte[i];
      repeat (CPB) @(negedge clk);
    end
    rx = frameByte[4];
    repeat (CPB / 2) @(negedge clk);
    check("mid-frame busy", busy, 1);
    reset = 1'b1;
    rx = 1'b1;
    #1;
    check("async reset busy", busy, 0);
    check("async reset dataOut", dataOut, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (32) @(negedge clk);
    check("aborted frame strobe", vldCyc.size() - nV, 0);
    sendByte(8'h42, 1'b1, sc);
    repeat (20) @(negedge clk);
    check("post-abort count", vldCyc.size() - nV, 1);
    check("post-abort dataOut", dataOut, 8'h42);
    check("post-abort framingError", ferrCyc.size() - nF, 0);

    check("strobe overlap", overlapCnt, 0);
    check("strobe repeat", repeatCnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive front end for the serial input path. It synchronises the asynchronous rx line, detects and validates start bits, samples 8N1 frames at mid-bit, and delivers each good byte as a single-cycle write strobe with data. Its outputs dataValid/dataOut connect directly to the writeEnable/data inputs of the UART ring buffer. Buffer full/overrun handling belongs to the ring buffer, not to this block.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit. Legal range is 4 and above; use 434 for 50 MHz at 115200 baud. Bit counter width is $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
rx  input  1  raw serial line, asynchronous to clk, idles high.
dataValid  output  1  one-cycle strobe: dataOut holds a newly received good byte. Drives ring writeEnable.
dataOut  output  8  last good byte received, LSB first on the wire. Holds between strobes.
framingError  output  1  one-cycle strobe: stop bit sampled low.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high): both synchroniser flops = 1, state = IDLE, count = 0, bitIndex = 0, shift register = 0, dataOut = 0x00, dataValid = 0, framingError = 0, busy = 0.
- Synchroniser: 2-flop chain on rx produces syncRx. Latency is 2 cycles. Only syncRx is used by the rest of the block.
- All outputs are registered; there are no combinational paths from rx.
- State IDLE:
  - count = 0.
  - syncRx == 0 -> START.
- State START:
  - count increments each cycle.
  - When count == (CLKS_PER_BIT-1)/2 (integer division), sample syncRx.
  - Sample 0 -> DATA, with count = 0 and bitIndex = 0.
  - Sample 1 -> false start -> IDLE. No strobe is generated.
- State DATA:
  - When count == CLKS_PER_BIT-1: shift[bitIndex] <= syncRx, count = 0, bitIndex++.
  - After bitIndex 7 is sampled -> STOP.
- State STOP:
  - When count == CLKS_PER_BIT-1, sample syncRx.
  - Sample 1: dataOut <= shift, dataValid = 1 for exactly one cycle, -> IDLE.
  - Sample 0: framingError = 1 for exactly one cycle, dataOut unchanged, no dataValid, -> BREAK.
- State BREAK: wait for syncRx == 1, then -> IDLE. This prevents a held-low line (break) from re-triggering START.
- dataValid and framingError are never high in the same cycle, and are never high for 2 consecutive cycles.
- Timing:
  - The mid-stop sample leaves about half a bit of idle high before the next start edge.
  - Back-to-back frames with one stop bit must be received with no loss.
  - dataValid rises 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles after the rx falling edge, with +/-2 cycles tolerance.
- Glitch rejection: a low pulse shorter than (CLKS_PER_BIT-1)/2 cycles is rejected in START.
- No receive FIFO and no back-pressure. The consumer must accept every strobe; the ring buffer drops a byte when it is full.
- Reset mid-frame:
  - The frame is aborted immediately; no strobe is produced during or after reset for that frame.
  - After release, if rx is still low, it is treated as a start edge. Such a frame is undefined and may produce framingError.
- Baud tolerance: the sample point must stay within the bit for +/-3% clock mismatch at CLKS_PER_BIT=16.

Test Plan:
(All scenarios use CLKS_PER_BIT=16, rx idle high, and drive frames with exact 16-cycle bit times.)
1. Reset with rx=1 -> dataOut=0x00, dataValid=0, framingError=0, busy=0. Then send 0xA5 -> single dataValid pulse 151-155 cycles after the start edge, dataOut=0xA5, busy=0 afterwards.
2. Send 0x01 then 0xFF back-to-back, one stop bit each -> two dataValid pulses 160+/-1 cycles apart, dataOut 0x01 then 0xFF, framingError never asserted.
3. Drive rx low for 3 cycles, then high -> no dataValid, no framingError, busy returns to 0 within 10 cycles.
4. Send 0x3C with the stop bit driven 0 and the line held low for 20 bit times -> one framingError pulse, no dataValid, dataOut keeps its prior value, busy stays 1 until rx returns high. A following 0x55 is then received correctly (dataValid, dataOut=0x55).
5. Assert reset during data bit 4 of 0x96 for 3 cycles, then idle high for 32 cycles and send 0x42 -> no strobe for 0x96, exactly one dataValid with dataOut=0x42.
6. Connect to the ring buffer and send 0x11, 0x22, 0x33; then assert readEnable -> ring returns 0x11, 0x22, 0x33 in order with dataReadAck on each.
